alu_op_sequencer: RTL and testbench

- Initiator-side driver for the team's 4-bit-in / 8-bit-accumulator ALU.
- Holds a small program of {function, operand} entries and clears the ALU accumulator.
- Issues each entry to the ALU, captures the registered result after each op, and reports completion through a start/busy/done handshake.
- Sits between test/control logic and the ALU; owns the ALU's Data, Function and synchronous clear inputs.

---
 rtl/alu_op_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a 4-bit-in / 8-bit-accumulator ALU from a small
// program of {function, operand} entries. A start pulse clears the ALU,
// then issues each entry every two cycles and captures the registered
// result. Completion is reported with busy/done.
//
// Optional build macro: ALU_SEQ_CHECK_EN. When defined, each entry also
// stores an expected result. The first capture that differs sets a sticky
// mismatch flag and records the entry index in err_idx.
module alu_op_sequencer #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 4,
  parameter  int RES_W  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset_b,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [2:0]        load_func,
  input  logic [DATA_W-1:0] load_data,
  input  logic [RES_W-1:0]  load_exp,
  input  logic [AW-1:0]     prog_last,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  last_result,
  output logic              mismatch,
  output logic [AW-1:0]     err_idx,
  output logic [DATA_W-1:0] alu_data,
  output logic [2:0]        alu_func,
  output logic              alu_reset_b,
  input  logic [RES_W-1:0]  alu_result
);

  localparam logic [2:0] FUNC_HOLD = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            state;
  logic [AW-1:0]     pc;
  logic [AW-1:0]     last_idx;
  logic [AW-1:0]     next_pc;
  logic              prog_we;

  logic [2:0]        func_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // The program can only be rewritten while no run is in progress.
  assign prog_we = (state == S_IDLE) && load_we;
  assign next_pc = pc + 1'b1;

  // Program storage write port.
  // NOTE: memories have no reset; a reset branch here would turn the
  // array into flops and the contents are defined only by writes anyway.
  always_ff @(posedge Clock) begin
    if (prog_we) begin
      func_mem[load_addr] <= load_func;
      data_mem[load_addr] <= load_data;
    end
  end

  // Sequencer FSM: every output is registered and takes its value on the
  // edge that enters the state it belongs to.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state       <= S_IDLE;
      pc          <= '0;
      last_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      last_result <= '0;
      alu_data    <= '0;
      alu_func    <= FUNC_HOLD;
      alu_reset_b <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          alu_func <= FUNC_HOLD;
          alu_data <= '0;
          if (start) begin
            state       <= S_CLEAR;
            last_idx    <= prog_last;
            pc          <= '0;
            busy        <= 1'b1;
            alu_reset_b <= 1'b0;
          end else begin
            alu_reset_b <= 1'b1;
          end
        end
        S_CLEAR: begin
          // The ALU clears on this edge; issue the first entry next.
          state       <= S_ISSUE;
          alu_reset_b <= 1'b1;
          alu_func    <= func_mem[pc];
          alu_data    <= data_mem[pc];
        end
        S_ISSUE: begin
          // The ALU latches the op on this edge; hold it afterwards.
          state    <= S_CAPTURE;
          alu_func <= FUNC_HOLD;
          alu_data <= '0;
        end
        S_CAPTURE: begin
          last_result <= alu_result;
          if (pc == last_idx) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_ISSUE;
            pc       <= next_pc;
            alu_func <= func_mem[next_pc];
            alu_data <= data_mem[next_pc];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [RES_W-1:0] exp_mem [DEPTH];

  // Expected-result storage, written alongside the program.
  always_ff @(posedge Clock) begin
    if (prog_we) begin
      exp_mem[load_addr] <= load_exp;
    end
  end

  // Sticky compare: cleared when a run starts, records only the first miss.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      mismatch <= 1'b0;
      err_idx  <= '0;
    end else if (state == S_IDLE && start) begin
      mismatch <= 1'b0;
      err_idx  <= '0;
    end else if (state == S_CAPTURE && !mismatch && alu_result != exp_mem[pc]) begin
      mismatch <= 1'b1;
      err_idx  <= pc;
    end
  end
`else
  logic unused_exp;

  assign unused_exp = ^load_exp;
  assign mismatch   = 1'b0;
  assign err_idx    = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached.
// ALU function codes used here: 000 load, 001 add, 010 sub, 011 and-low,
// 100 or-low, 101 and with operand in the upper nibble, 110 multiply,
// 111 hold. The ALU clears synchronously while alu_reset_b is low.
module tb_alu_op_sequencer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 4;
  localparam int RES_W  = 8;
  localparam int AW     = 3;

  logic              clk;
  logic              rst_n;
  logic              load_we;
  logic [AW-1:0]     load_addr;
  logic [2:0]        load_func;
  logic [DATA_W-1:0] load_data;
  logic [RES_W-1:0]  load_exp;
  logic [AW-1:0]     prog_last;
  logic              start;
  logic              busy;
  logic              done;
  logic [RES_W-1:0]  last_result;
  logic              mismatch;
  logic [AW-1:0]     err_idx;
  logic [DATA_W-1:0] alu_data;
  logic [2:0]        alu_func;
  logic              alu_reset_b;
  logic [RES_W-1:0]  alu_result;
  logic [RES_W-1:0]  alu_acc;

  int n_checks = 0;
  int n_errors = 0;

  // Bench copy of the program as written into the DUT.
  logic [2:0]       pfunc [DEPTH];
  logic [3:0]       pdata [DEPTH];
  logic [RES_W-1:0] exp_q [$];

  typedef struct {
    logic [11:0] funcs;
    logic [15:0] datas;
    int          last;
    logic [7:0]  exp_final;
  } vec_t;

  vec_t vecs [5];

  alu_op_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .Clock      (clk),
    .Reset_b    (rst_n),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_func  (load_func),
    .load_data  (load_data),
    .load_exp   (load_exp),
    .prog_last  (prog_last),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .last_result(last_result),
    .mismatch   (mismatch),
    .err_idx    (err_idx),
    .alu_data   (alu_data),
    .alu_func   (alu_func),
    .alu_reset_b(alu_reset_b),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [2:0] f,
                                       input logic [3:0] d);
    case (f)
      3'b000:  return {4'h0, d};
      3'b001:  return a + {4'h0, d};
      3'b010:  return a - {4'h0, d};
      3'b011:  return a & {4'h0, d};
      3'b100:  return a | {4'h0, d};
      3'b101:  return a & {d, 4'h0};
      3'b110:  return a * {4'h0, d};
      default: return a;
    endcase
  endfunction

  // Behavioural ALU with registered accumulator output.
  always @(posedge clk) begin
    if (!alu_reset_b) alu_acc <= '0;
    else              alu_acc <= alu_f(alu_acc, alu_func, alu_data);
  end
  assign alu_result = alu_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_entry(input int addr, input logic [2:0] f, input logic [3:0] d,
                            input logic [7:0] e);
    load_we   = 1'b1;
    load_addr = AW'(addr);
    load_func = f;
    load_data = d;
    load_exp  = e;
    pfunc[addr] = f;
    pdata[addr] = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Writes a vector's program; entry 'bad' gets a deliberately wrong exp.
  task automatic load_vec(input vec_t v, input int bad);
    logic [7:0] acc = '0;
    logic [2:0] f;
    logic [3:0] d;
    for (int i = 0; i <= v.last; i++) begin
      f   = v.funcs[3*i +: 3];
      d   = v.datas[4*i +: 4];
      acc = alu_f(acc, f, d);
      load_entry(i, f, d, (i == bad) ? (acc ^ 8'h01) : acc);
    end
  endtask

  // Starts a run from a negedge and follows it to done. Captured results are
  // compared against the scoreboard two cycles after each observed ISSUE.
  // poke_at/write_at/reset_at are cycle numbers after the start edge (-1 = off).
  task automatic run_prog(input string name, input int pl, input logic [7:0] exp_final,
                          input int poke_at, input int write_at, input int reset_at,
                          input bit poke_done, input bit exp_mis, input int exp_err);
    logic [7:0] acc = '0;
    bit issue_prev = 1'b0;
    bit cap_due = 1'b0;
    int c = 0;
    exp_q.delete();
    for (int i = 0; i <= pl; i++) begin
      acc = alu_f(acc, pfunc[i], pdata[i]);
      exp_q.push_back(acc);
    end
    prog_last = AW'(pl);
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    load_we = 1'b0;
    check({name, " clear busy"}, 32'(busy), 32'd1);
    check({name, " clear alu_reset_b"}, 32'(alu_reset_b), 32'd0);
    forever begin
      if (cap_due) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s capture: got 0x%0h, expected no capture", name, last_result);
        end else begin
          check({name, " capture"}, 32'(last_result), 32'(exp_q.pop_front()));
        end
      end
      cap_due    = issue_prev;
      issue_prev = busy && alu_reset_b && (alu_func != 3'b111);
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check({name, " rst busy"}, 32'(busy), 32'd0);
        check({name, " rst done"}, 32'(done), 32'd0);
        check({name, " rst alu_func"}, 32'(alu_func), 32'h7);
        check({name, " rst alu_reset_b"}, 32'(alu_reset_b), 32'd0);
        check({name, " rst last_result"}, 32'(last_result), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check({name, " post-rst no done"}, 32'(done), 32'd0);
          check({name, " post-rst idle busy"}, 32'(busy), 32'd0);
        end
        return;
      end
      if (done) break;
      start = (c == poke_at);
      if (c == write_at) begin
        load_we   = 1'b1;
        load_addr = '0;
        load_func = 3'b001;
        load_data = 4'hA;
        load_exp  = 8'h00;
      end else begin
        load_we = 1'b0;
      end
      if (c >= 300) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s timeout: got no done after %0d cycles, expected %0d", name, c, 2*pl+3);
        start   = 1'b0;
        load_we = 1'b0;
        return;
      end
      @(negedge clk);
      c++;
    end
    check({name, " done cycle"}, 32'(c), 32'(2*pl + 3));
    check({name, " done busy"}, 32'(busy), 32'd0);
    check({name, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
    check({name, " last_result"}, 32'(last_result), 32'(exp_final));
`ifdef ALU_SEQ_CHECK_EN
    check({name, " mismatch"}, 32'(mismatch), 32'(exp_mis));
    if (exp_mis) check({name, " err_idx"}, 32'(err_idx), 32'(exp_err));
`else
    check({name, " mismatch"}, 32'(mismatch), 32'd0);
    check({name, " err_idx"}, 32'(err_idx), 32'd0);
`endif
    start = poke_done;
    @(negedge clk);
    start = 1'b0;
    check({name, " done one cycle"}, 32'(done), 32'd0);
    if (poke_done) begin
      for (int k = 0; k < 4; k++) begin
        check({name, " start in done ignored"}, 32'(busy || !alu_reset_b), 32'd0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    vecs[0] = '{funcs: {3'b101, 3'b110, 3'b001, 3'b000}, datas: 16'h1335, last: 3, exp_final: 8'h10};
    vecs[1] = '{funcs: {3'b000, 3'b000, 3'b000, 3'b000}, datas: 16'h000F, last: 0, exp_final: 8'h0F};
    vecs[2] = '{funcs: {3'b000, 3'b000, 3'b010, 3'b000}, datas: 16'h0053, last: 1, exp_final: 8'hFE};
    vecs[3] = '{funcs: {3'b000, 3'b011, 3'b110, 3'b000}, datas: 16'h0CF9, last: 2, exp_final: 8'h04};
    vecs[4] = '{funcs: {3'b001, 3'b110, 3'b110, 3'b000}, datas: 16'h1FFF, last: 3, exp_final: 8'h30};

    rst_n     = 1'b1;
    load_we   = 1'b0;
    load_addr = '0;
    load_func = '0;
    load_data = '0;
    load_exp  = '0;
    prog_last = '0;
    start     = 1'b0;

    // Asynchronous reset applied before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset alu_func", 32'(alu_func), 32'h7);
    check("reset alu_reset_b", 32'(alu_reset_b), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset last_result", 32'(last_result), 32'd0);
    check("reset alu_data", 32'(alu_data), 32'd0);
    check("reset mismatch", 32'(mismatch), 32'd0);
    check("reset err_idx", 32'(err_idx), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle alu_reset_b", 32'(alu_reset_b), 32'd1);

    // Table-driven programs.
    for (int v = 0; v < 5; v++) begin
      load_vec(vecs[v], -1);
      run_prog($sformatf("vec%0d", v), vecs[v].last, vecs[v].exp_final, -1, -1, -1, 1'b0, 1'b0, 0);
    end

    // Single-op program run twice: accumulator must be cleared each run.
    load_vec(vecs[1], -1);
    run_prog("single run1", 0, 8'h0F, -1, -1, -1, 1'b0, 1'b0, 0);
    run_prog("single run2", 0, 8'h0F, -1, -1, -1, 1'b0, 1'b0, 0);

    // Write and start in the same idle cycle: the new entry is used.
    load_we   = 1'b1;
    load_addr = '0;
    load_func = 3'b000;
    load_data = 4'h7;
    load_exp  = 8'h07;
    pfunc[0]  = 3'b000;
    pdata[0]  = 4'h7;
    run_prog("write+start", 0, 8'h07, -1, -1, -1, 1'b0, 1'b0, 0);

    // Start while busy, write while busy, start in DONE: all ignored.
    load_vec(vecs[0], -1);
    run_prog("handshake", 3, 8'h10, 5, 6, -1, 1'b1, 1'b0, 0);
    run_prog("handshake rerun", 3, 8'h10, -1, -1, -1, 1'b0, 1'b0, 0);

    // Reset after the second ISSUE, then a clean full run.
    run_prog("midrun reset", 3, 8'h10, -1, -1, 4, 1'b0, 1'b0, 0);
    run_prog("after reset", 3, 8'h10, -1, -1, -1, 1'b0, 1'b0, 0);

    // Full-depth program: pc must reach DEPTH-1 without wrapping.
    load_entry(0, 3'b000, 4'h1, 8'h01);
    for (int i = 1; i < DEPTH; i++) load_entry(i, 3'b001, 4'h1, 8'(i + 1));
    run_prog("full depth", DEPTH - 1, 8'h08, -1, -1, -1, 1'b0, 1'b0, 0);

    // Expected-result compare: bad exp at entry 2, then corrected.
    load_vec(vecs[0], 2);
    run_prog("exp bad", 3, 8'h10, -1, -1, -1, 1'b0, 1'b1, 2);
    load_vec(vecs[0], -1);
    run_prog("exp good", 3, 8'h10, -1, -1, -1, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
